gcd_engine: RTL and testbench

Parametrised, handshaked greatest-common-divisor engine, the next generation of the board-level GCD calculator. It accepts two WIDTH-bit operands on a valid/ready input port and converts them to magnitudes when signed. It iterates to the GCD and presents the result, an iteration count and a zero-operand flag on a valid/ready output port. The board top (switch/key capture, LED drive) instantiates it as the arithmetic core.

---
 rtl/gcd_engine_pkg.sv | 21 ++
 rtl/gcd_engine_if.sv | 24 ++
 rtl/gcd_engine_abs.sv | 19 +
 rtl/gcd_engine.sv | 154 +++++++++++++++
 tb/tb_gcd_engine.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_engine_pkg.sv
// Shared types and width helpers for the GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } gcd_state_t;

  // Iteration counter width: one bit wider than the operands so the
  // subtractive worst case (2^WIDTH - 1 steps) never saturates.
  function automatic int unsigned cnt_w(input int unsigned width);
    return width + 1;
  endfunction

  // Stein shift counter width: enough to count every common factor of two.
  function automatic int unsigned k_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result valid-ready handshake bundle for gcd_engine.
interface gcd_engine_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH:0]   cycles_out;
  logic             zero_err;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, cycles_out, zero_err
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, cycles_out, zero_err
  );
endinterface

// File: rtl/gcd_engine_abs.sv
// gcd_abs: combinational operand-to-magnitude conversion.
// With SIGNED_IN the most-negative value maps to 2^(WIDTH-1) read unsigned.
module gcd_abs #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_IN = 1'b1
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] mag
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Two's complement negate when the operand is negative and signed.
  always_comb begin
    mag = x;
    if (SIGNED_IN && x[WIDTH-1]) begin
      mag = ~x + ONE;
    end
  end
endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: handshaked GCD core (subtractive by default).
// Define GCD_STEIN_EN to build the binary (Stein) reduction instead.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_IN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  gcd_engine_if.slave  bus
);
  localparam int unsigned CW = cnt_w(WIDTH);
`ifdef GCD_STEIN_EN
  localparam int unsigned KW = k_w(WIDTH);
`endif

  gcd_state_t       state, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] gcd_q, gcd_d, result;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             zero_q, zero_d;
  logic             ov_q, ov_d;
  logic             finish;
`ifdef GCD_STEIN_EN
  logic [KW-1:0]    k_q, k_d;
`endif

  gcd_abs #(.WIDTH(WIDTH), .SIGNED_IN(SIGNED_IN)) u_abs_a (.x(bus.a_in), .mag(a_mag));
  gcd_abs #(.WIDTH(WIDTH), .SIGNED_IN(SIGNED_IN)) u_abs_b (.x(bus.b_in), .mag(b_mag));

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = ov_q;
  assign bus.gcd_out    = gcd_q;
  assign bus.cycles_out = cyc_q;
  assign bus.zero_err   = zero_q;

  // Next-state, reduction step and result capture.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gcd_d   = gcd_q;
    cyc_d   = cyc_q;
    zero_d  = zero_q;
    ov_d    = ov_q;
    finish  = 1'b0;
    result  = '0;
`ifdef GCD_STEIN_EN
    k_d     = k_q;
`endif
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          cnt_d   = '0;
`ifdef GCD_STEIN_EN
          k_d     = '0;
`endif
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        cnt_d = cnt_inc;
`ifdef GCD_STEIN_EN
        if (a_q == '0) begin
          finish = 1'b1;
          result = b_q << k_q;
        end else if (b_q == '0 || a_q == b_q) begin
          finish = 1'b1;
          result = a_q << k_q;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
`else
        if (a_q == '0) begin
          finish = 1'b1;
          result = b_q;
        end else if (b_q == '0 || a_q == b_q) begin
          finish = 1'b1;
          result = a_q;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
`endif
        if (finish) begin
          gcd_d   = result;
          cyc_d   = cnt_inc;
          zero_d  = (a_q == '0) && (b_q == '0);
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Operand, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      gcd_q  <= '0;
      cyc_q  <= '0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
`ifdef GCD_STEIN_EN
      k_q    <= '0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      gcd_q  <= gcd_d;
      cyc_q  <= cyc_d;
      zero_q <= zero_d;
      ov_q   <= ov_d;
`ifdef GCD_STEIN_EN
      k_q    <= k_d;
`endif
    end
  end
endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: an unsigned and a signed instance driven in parallel,
// checked each cycle against a transaction-level arithmetic model.
module tb_gcd_engine;
  localparam int W   = 8;
  localparam int SAT = 2 ** (W + 1) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;

  always #5 clk = ~clk;

  gcd_engine_if #(.WIDTH(W)) bus_u ();
  gcd_engine_if #(.WIDTH(W)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.a_in      = a_in;
  assign bus_u.b_in      = b_in;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.a_in      = a_in;
  assign bus_s.b_in      = b_in;
  assign bus_s.out_ready = out_ready;

  gcd_engine #(.WIDTH(W), .SIGNED_IN(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bus_u.slave));
  gcd_engine #(.WIDTH(W), .SIGNED_IN(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

  logic         ir[2], ov[2], ze[2];
  logic [W-1:0] go[2];
  logic [W:0]   co[2];
  assign ir[0] = bus_u.in_ready;  assign ir[1] = bus_s.in_ready;
  assign ov[0] = bus_u.out_valid; assign ov[1] = bus_s.out_valid;
  assign ze[0] = bus_u.zero_err;  assign ze[1] = bus_s.zero_err;
  assign go[0] = bus_u.gcd_out;   assign go[1] = bus_s.gcd_out;
  assign co[0] = bus_u.cycles_out; assign co[1] = bus_s.cycles_out;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag(input int x, input bit sgn);
    if (sgn && x >= 2 ** (W - 1)) return 2 ** W - x;
    return x;
  endfunction

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reduction steps including the terminating one.
  function automatic int steps_ref(input int a, input int b);
    int n = 0;
`ifdef GCD_STEIN_EN
    forever begin
      n++;
      if (a == 0 || b == 0 || a == b) break;
      if (a % 2 == 0 && b % 2 == 0) begin a /= 2; b /= 2; end
      else if (a % 2 == 0) a /= 2;
      else if (b % 2 == 0) b /= 2;
      else if (a > b) a -= b;
      else b -= a;
    end
    return n;
`else
    int t;
    // Subtractive step count equals the sum of Euclid quotients.
    if (a == 0 || b == 0) return 1;
    while (b != 0) begin
      n += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return n;
`endif
  endfunction

  // Model: 0 idle, 1 busy, 2 result held.
  int m_st[2]    = '{default: 0};
  int m_rem[2]   = '{default: 0};
  int m_valid[2] = '{default: 0};
  int m_gcd[2]   = '{default: 0};
  int m_cyc[2]   = '{default: 0};
  int m_zero[2]  = '{default: 0};
  int p_gcd[2], p_cyc[2], p_zero[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_st[d] = 0; m_valid[d] = 0; m_gcd[d] = 0; m_cyc[d] = 0; m_zero[d] = 0;
      end else begin
        case (m_st[d])
          0: if (in_valid) begin
            int ma, mb, s;
            ma = mag(int'(a_in), d == 1);
            mb = mag(int'(b_in), d == 1);
            s  = steps_ref(ma, mb);
            p_gcd[d]  = gcd_ref(ma, mb);
            p_cyc[d]  = (s > SAT) ? SAT : s;
            p_zero[d] = (ma == 0 && mb == 0) ? 1 : 0;
            m_rem[d]  = s;
            m_st[d]   = 1;
          end
          1: begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
              m_valid[d] = 1; m_gcd[d] = p_gcd[d]; m_cyc[d] = p_cyc[d];
              m_zero[d] = p_zero[d]; m_st[d] = 2;
            end
          end
          default: if (out_ready) begin
            m_valid[d] = 0; m_st[d] = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), (m_st[d] == 0) ? 1 : 0);
      chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), m_valid[d]);
      chk($sformatf("gcd_out[%0d]", d), 32'(go[d]), m_gcd[d]);
      chk($sformatf("cycles_out[%0d]", d), 32'(co[d]), m_cyc[d]);
      chk($sformatf("zero_err[%0d]", d), 32'(ze[d]), m_zero[d]);
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(ir[0] && ir[1]) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(ir[0] && ir[1]), 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!(ov[0] && ov[1]) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_timeout"}, 32'(ov[0] && ov[1]), 1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle("send");
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gcd", 32'(go[0]), 0);
    chk("rst_cycles", 32'(co[0]), 0);
    chk("rst_out_valid", 32'(ov[1]), 0);
    chk("rst_in_ready", 32'(ir[1]), 1);
    rst = 1'b0;
    @(negedge clk);

    send(8'd12, 8'd18);
    wait_idle("t12_18");
    chk("t12_18_gcd_u", 32'(go[0]), 6);
    chk("t12_18_gcd_s", 32'(go[1]), 6);
    chk("t12_18_zero", 32'(ze[0]), 0);
`ifdef GCD_STEIN_EN
    chk("t12_18_cycles", 32'(co[0]), 5);
`else
    chk("t12_18_cycles", 32'(co[0]), 3);
`endif

    send(8'hF4, 8'h12);
    wait_idle("neg12");
    chk("neg12_gcd_s", 32'(go[1]), 6);
    chk("neg12_gcd_u", 32'(go[0]), 2);

    send(8'h80, 8'h40);
    wait_idle("mostneg");
    chk("mostneg_gcd_s", 32'(go[1]), 64);
    chk("mostneg_gcd_u", 32'(go[0]), 64);

    send(8'd0, 8'd0);
    wait_idle("zero0");
    chk("zero0_gcd", 32'(go[0]), 0);
    chk("zero0_err", 32'(ze[1]), 1);
    chk("zero0_cycles", 32'(co[0]), 1);

    send(8'd0, 8'd9);
    wait_idle("zero9");
    chk("zero9_gcd", 32'(go[1]), 9);
    chk("zero9_err", 32'(ze[0]), 0);
    chk("zero9_cycles", 32'(co[1]), 1);

    out_ready = 1'b0;
    send(8'd35, 8'd14);
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a_in = 8'd3; b_in = 8'd9; in_valid = 1'b1; end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp_gcd_held", 32'(go[0]), 7);
    chk("bp_in_ready", 32'(ir[1]), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(ir[0]), 1);
    chk("bp_release_valid", 32'(ov[0]), 0);

    send(8'd255, 8'd1);
    wait_idle("worst");
    chk("worst_gcd", 32'(go[0]), 1);
`ifdef GCD_STEIN_EN
    chk("worst_cycles_bound", 32'(co[0] <= 32), 1);
`else
    chk("worst_cycles", 32'(co[0]), 255);
`endif

    send(8'd255, 8'd1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(ov[0]), 0);
    chk("abort_gcd", 32'(go[0]), 0);
    chk("abort_cycles", 32'(co[0]), 0);
    chk("abort_in_ready", 32'(ir[0]), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
